pcie_egress_arbiter: RTL
========================

Name: pcie_egress_arbiter

Overview:
- Downstream of the four-lane output FIFO stage (destination FIFOs 4..7).
- Pops the non-empty lanes in round-robin order, one word per cycle, and drives a single serialized data stream toward the link side.
- Honours a sink backpressure signal.
- Keeps a per-lane forwarded-word counter that can be read with the team's req/idx counter-read protocol.

Parameters:
- DATA_W, 12, word width; matches the output FIFO data width.
- CNT_W, 5, width of each per-lane forwarded-word counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- fifo_empty  in  4  empty flag per lane; bit i = lane i (lane 0 = FIFO4 ... lane 3 = FIFO7).
- data_in0  in  DATA_W  read data of lane 0; valid the cycle after its pop.
- data_in1  in  DATA_W  read data of lane 1; same timing.
- data_in2  in  DATA_W  read data of lane 2; same timing.
- data_in3  in  DATA_W  read data of lane 3; same timing.
- sink_ready  in  1  downstream can accept a word issued this cycle.
- req  in  1  counter read request.
- idx  in  3  counter select; 0..3 valid.
- pop  out  4  one-hot pop to the output FIFOs.
- data_out  out  DATA_W  registered serialized word.
- valid_out  out  1  data_out valid this cycle.
- data_cont  out  CNT_W  counter read data.
- valid_cont  out  1  data_cont valid.
- idle  out  1  FSM in IDLE.

Behaviour:
- Reset (reset=0 at a clk edge):
  - pop=0, data_out=0, valid_out=0, data_cont=0, valid_cont=0, idle=1.
  - All counters 0, rr pointer = lane 0, state=IDLE.
- State machine:
  - IDLE: enter ACTIVE when any fifo_empty bit is 0 and sink_ready=1; enter STALL when any lane is non-empty and sink_ready=0.
  - ACTIVE: issue one pop per cycle. Go to STALL when sink_ready=0. Go to IDLE when all lanes are empty, sink_ready=1, and no word is in flight.
  - STALL: pop=0. Return to ACTIVE when sink_ready=1 and a lane is non-empty; return to IDLE when sink_ready=1 and all lanes are empty.
- Pop rule:
  - Pop lane i in cycle N only if fifo_empty[i]=0 and sink_ready=1 in cycle N.
  - Never pop an empty lane; pop is always one-hot or zero.
- Grant: round-robin, starting the search at the rr pointer. After a grant to lane g, the pointer becomes (g+1) mod 4.
- Latency:
  - The word popped in cycle N appears in data_out with valid_out=1 in cycle N+1.
  - The sink must accept it even if sink_ready has dropped in N+1 (one cycle of slack).
- Throughput: 1 word/cycle when lanes stay non-empty and sink_ready=1.
- Counters:
  - counter[g] increments when the word from lane g is output (cycle N+1).
  - Counters wrap from 2^CNT_W-1 to 0.
- Counter read:
  - req=1 at cycle N with idx<4 gives data_cont=counter[idx] and valid_cont=1 at N+1. The value returned is the counter before any same-cycle increment.
  - idx>=4 gives valid_cont=0 and data_cont=0.
  - req=0 gives valid_cont=0 and data_cont holds its last value.
- Reset mid-stream: an in-flight word is dropped (valid_out=0 next cycle) and the counters clear.
- Lane going empty in the same cycle as its pop is legal; the FIFO flag reflects its pre-pop state.

Optional Feature:
- LANE_TAG_EN defined:
  - Extra output lane_out (2 bits), registered alongside data_out, giving the source lane of the word.
  - lane_out resets to 0.
- LANE_TAG_EN undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, ACTIVE=2'd1, STALL=2'd2);
  - NUM_LANES=4 and the lane-index width;
  - the default DATA_W/CNT_W constants.
- One natural sub-module: rr_arbiter4, a combinational round-robin grant from (request vector, pointer) to one-hot grant. Pointer update stays in the top module.

Test Plan:
1. Reset held low for 2 cycles, then released with all lanes empty → idle=1, pop=0, valid_out=0, all counters read 0.
2. Lanes 0 and 2 non-empty with data 12'h0FB and 12'h2BB, sink_ready=1:
   - pops alternate 0001, 0100, 0001, …;
   - data_out follows one cycle later;
   - counter[0] and counter[2] increment once per word.
3. All four lanes non-empty for 8 cycles → pop sequence 0001, 0010, 0100, 1000, repeating; 8 consecutive valid_out cycles.
4. sink_ready dropped in cycle N during streaming:
   - pop=0 from N;
   - the word popped at N-1 is still output at N;
   - state=STALL;
   - pops resume with the next rr lane after sink_ready=1.
5. Forward 33 words from lane 3, then req=1, idx=3 → next cycle valid_cont=1, data_cont=1 (wrap). A request with idx=5 gives valid_cont=0.
6. Reset asserted while a word is in flight → valid_out=0 on the following cycle, counters 0, rr pointer back at lane 0. With LANE_TAG_EN, lane_out=0.

Source files
------------

// File: rtl/pcie_egress_arbiter_pkg.sv
// Shared definitions for the PCIe egress arbiter: FSM encoding, lane geometry, default widths.
package pcie_egress_arbiter_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_W     = 2;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    function automatic logic [LANE_W-1:0] onehot_to_lane(input logic [NUM_LANES-1:0] oh);
        logic [LANE_W-1:0] lane;
        lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (oh[i]) lane = LANE_W'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/pcie_egress_arbiter_rr_arbiter4.sv
// Combinational 4-way round-robin grant; the search starts at ptr and wraps.
module rr_arbiter4
    import pcie_egress_arbiter_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    ptr,
    output logic [NUM_LANES-1:0] gnt
);

    logic [LANE_W-1:0] lane;
    logic              found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        lane  = ptr;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane = ptr + LANE_W'(k);
            if (!found && req[lane]) begin
                gnt[lane] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// Serializes four output-FIFO lanes round-robin onto one stream, with per-lane forwarded-word counters.
// Optional source-lane tag output is enabled by defining LANE_TAG_EN.
//
// state  | meaning
// IDLE   | all lanes empty, nothing popped
// ACTIVE | popping one non-empty lane per cycle while the sink is ready
// STALL  | sink backpressure, no pops
module pcie_egress_arbiter
    import pcie_egress_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] fifo_empty,
    input  logic [DATA_W-1:0]    data_in0,
    input  logic [DATA_W-1:0]    data_in1,
    input  logic [DATA_W-1:0]    data_in2,
    input  logic [DATA_W-1:0]    data_in3,
    input  logic                 sink_ready,
    input  logic                 req,
    input  logic [2:0]           idx,
    output logic [NUM_LANES-1:0] pop,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid_out,
    output logic [CNT_W-1:0]     data_cont,
    output logic                 valid_cont,
    output logic                 idle
`ifdef LANE_TAG_EN
    ,
    output logic [LANE_W-1:0]    lane_out
`endif
);

    state_t                state_q, state_d;
    logic [LANE_W-1:0]     rr_ptr_q;
    logic [LANE_W-1:0]     lane_q;
    logic                  valid_q;
    logic [CNT_W-1:0]      cnt_q [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_req, gnt;
    logic [LANE_W-1:0]     gnt_lane;
    logic                  any_req, pop_en;

    assign lane_req = ~fifo_empty;
    assign any_req  = |lane_req;
    assign gnt_lane = onehot_to_lane(gnt);

    rr_arbiter4 u_rr (
        .req (lane_req),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        state_d = state_q;
        pop_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = sink_ready ? ST_ACTIVE : ST_STALL;
            end
            ST_ACTIVE: begin
                pop_en = sink_ready && any_req;
                if (!sink_ready)                state_d = ST_STALL;
                else if (!any_req && !valid_q)  state_d = ST_IDLE;
            end
            ST_STALL: begin
                if (sink_ready) state_d = any_req ? ST_ACTIVE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // No pop during a reset cycle: the word would be lost with the dropped in-flight slot.
        if (!reset) pop_en = 1'b0;
    end

    assign pop = pop_en ? gnt : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lane_q     <= '0;
            valid_q    <= 1'b0;
            data_cont  <= '0;
            valid_cont <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= pop_en;
            if (pop_en) begin
                lane_q   <= gnt_lane;
                rr_ptr_q <= gnt_lane + LANE_W'(1);
            end
            if (valid_q) cnt_q[lane_q] <= cnt_q[lane_q] + CNT_W'(1);
            // Read returns the pre-increment value since cnt_q is sampled before this edge updates it.
            if (req) begin
                if (idx < 3'(NUM_LANES)) begin
                    data_cont  <= cnt_q[idx[LANE_W-1:0]];
                    valid_cont <= 1'b1;
                end else begin
                    data_cont  <= '0;
                    valid_cont <= 1'b0;
                end
            end else begin
                valid_cont <= 1'b0;
            end
        end
    end

    // FIFO read data arrives the cycle after the pop, so the mux select is the registered lane.
    always_comb begin
        data_out = '0;
        if (valid_q) begin
            case (lane_q)
                2'd0:    data_out = data_in0;
                2'd1:    data_out = data_in1;
                2'd2:    data_out = data_in2;
                default: data_out = data_in3;
            endcase
        end
    end

    assign valid_out = valid_q;
    assign idle      = (state_q == ST_IDLE);

`ifdef LANE_TAG_EN
    assign lane_out = lane_q;
`endif

endmodule
